conv_layer_sched: RTL and testbench

Layer/tile scheduler for the convolution engine. Walks a fixed six-layer network held in the shared package. For each layer it steps through output-channel groups, tile rows, tile columns and input-channel groups, and issues one job descriptor per step over a valid/ready handshake. Each descriptor carries the source/destination activation bank select, tile coordinates, and weight/bias SRAM base addresses. A barrier at every layer boundary drains all outstanding jobs before the next layer starts, because layer l+1 reads what layer l wrote.

---
 rtl/conv_sched_pkg.sv | 38 +++
 rtl/conv_sched_cnt.sv | 61 ++++++
 rtl/conv_layer_sched.sv | 192 +++++++++++++++++++
 tb/tb_conv_layer_sched.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_sched_pkg.sv
// Shared tables and encodings for the convolution layer scheduler.
// The six-layer network shape lives here; the scheduler walks it as-is.
package conv_sched_pkg;

    localparam int NUM_LAYERS = 6;

    // Per-layer loop counts (a zero count is treated as 1 by the scheduler).
    localparam int unsigned OG    [NUM_LAYERS] = '{1, 2, 1, 1, 0, 2};
    localparam int unsigned IG    [NUM_LAYERS] = '{2, 1, 1, 1, 1, 1};
    localparam int unsigned TR    [NUM_LAYERS] = '{1, 1, 2, 1, 1, 1};
    localparam int unsigned TC    [NUM_LAYERS] = '{3, 1, 2, 1, 1, 1};

    // Weight / bias SRAM base addresses; sums wrap to the SRAM depth.
    localparam int unsigned WBASE [NUM_LAYERS] = '{0, 32, 64, 80, 96, 120};
    localparam int unsigned BBASE [NUM_LAYERS] = '{0, 4, 12, 16, 20, 30};

    // Activation bank selects.
    localparam logic [2:0] BANK_IMG   = 3'd0;
    localparam logic [2:0] BANK_FEAT1 = 3'd1;
    localparam logic [2:0] BANK_FEAT2 = 3'd2;
    localparam logic [2:0] BANK_FEAT3 = 3'd3;
    localparam logic [2:0] BANK_FEAT4 = 3'd4;
    localparam logic [2:0] BANK_FEAT5 = 3'd5;
    localparam logic [2:0] BANK_TEMP  = 3'd6;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        DRAIN  = 2'd2,
        FINISH = 2'd3
    } state_t;

    // Loop count with zero promoted to one so every level runs at least once.
    function automatic int unsigned eff_cnt(input int unsigned n);
        return (n == 0) ? 1 : n;
    endfunction

endpackage

// File: rtl/conv_sched_cnt.sv
// Cascaded nested counter: ig (innermost) -> tc -> tr -> og (outermost).
// Limits are loop counts (>=1); last_of_layer flags the final step of the nest.
module conv_sched_cnt #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         advance,
    input  logic [W-1:0] lim_ig,
    input  logic [W-1:0] lim_tc,
    input  logic [W-1:0] lim_tr,
    input  logic [W-1:0] lim_og,
    output logic [W-1:0] ig,
    output logic [W-1:0] tc,
    output logic [W-1:0] tr,
    output logic [W-1:0] og,
    output logic         last_of_layer
);

    logic ig_last, tc_last, tr_last, og_last;

    assign ig_last       = (ig == lim_ig - W'(1));
    assign tc_last       = (tc == lim_tc - W'(1));
    assign tr_last       = (tr == lim_tr - W'(1));
    assign og_last       = (og == lim_og - W'(1));
    assign last_of_layer = ig_last && tc_last && tr_last && og_last;

    // Ripple-carry style advance; every level wraps to 0 after its last value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ig <= '0;
            tc <= '0;
            tr <= '0;
            og <= '0;
        end else if (clr) begin
            ig <= '0;
            tc <= '0;
            tr <= '0;
            og <= '0;
        end else if (advance) begin
            if (!ig_last) begin
                ig <= ig + W'(1);
            end else begin
                ig <= '0;
                if (!tc_last) begin
                    tc <= tc + W'(1);
                end else begin
                    tc <= '0;
                    if (!tr_last) begin
                        tr <= tr + W'(1);
                    end else begin
                        tr <= '0;
                        og <= og_last ? '0 : og + W'(1);
                    end
                end
            end
        end
    end

endmodule

// File: rtl/conv_layer_sched.sv
// Layer/tile scheduler: walks the package network table and issues one job
// descriptor per (og, tr, tc, ig) step, with a drain barrier between layers.
// Optional CONV_SCHED_PERF_EN adds busy/stall performance counters.
module conv_layer_sched
    import conv_sched_pkg::*;
#(
    parameter int CH_NUM  = 4,
    parameter int TILE_W  = 6,
    parameter int MAX_OUT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              valid,
    output logic              job_valid,
    input  logic              job_ready,
    input  logic              job_done,
    output logic [2:0]        job_layer,
    output logic [2:0]        job_src_sel,
    output logic [2:0]        job_dst_sel,
    output logic [TILE_W-1:0] job_tile_row,
    output logic [TILE_W-1:0] job_tile_col,
    output logic              job_first_ig,
    output logic              job_last_ig,
    output logic [6:0]        job_waddr,
    output logic [4:0]        job_baddr,
    output logic              err_done
`ifdef CONV_SCHED_PERF_EN
    ,
    output logic [31:0]       perf_busy_cyc,
    output logic [31:0]       perf_stall_cyc
`endif
);

    localparam int              OUT_W      = $clog2(MAX_OUT + 1);
    localparam logic [OUT_W-1:0] MAX_Q     = OUT_W'(MAX_OUT);
    localparam logic [2:0]      LAST_LAYER = 3'(NUM_LAYERS - 1);

    state_t             state, state_nxt;
    logic [2:0]         layer;
    logic [OUT_W-1:0]   outstanding;
    logic               issue_st, hs, cnt_clr, drained, done_ok;
    logic [TILE_W-1:0]  lim_ig, lim_tc, lim_tr, lim_og;
    logic [TILE_W-1:0]  ig, tc, tr, og;
    logic               last_of_layer;
    logic [6:0]         waddr;
    logic [4:0]         baddr;

    // Effective loop limits for the current layer.
    assign lim_og = TILE_W'(eff_cnt(OG[layer]));
    assign lim_ig = TILE_W'(eff_cnt(IG[layer]));
    assign lim_tr = TILE_W'(eff_cnt(TR[layer]));
    assign lim_tc = TILE_W'(eff_cnt(TC[layer]));

    assign issue_st = (state == ISSUE);
    assign job_valid = issue_st && (outstanding < MAX_Q);
    assign hs        = job_valid && job_ready;
    assign drained   = (state == DRAIN) && (outstanding == '0);
    assign done_ok   = job_done && (outstanding != '0);
    assign busy      = issue_st || (state == DRAIN);
    assign valid     = (state == FINISH);

    conv_sched_cnt #(.W(TILE_W)) u_cnt (
        .clk           (clk),
        .rst           (rst),
        .clr           (cnt_clr),
        .advance       (hs),
        .lim_ig        (lim_ig),
        .lim_tc        (lim_tc),
        .lim_tr        (lim_tr),
        .lim_og        (lim_og),
        .ig            (ig),
        .tc            (tc),
        .tr            (tr),
        .og            (og),
        .last_of_layer (last_of_layer)
    );

    // Address arithmetic; results wrap to the SRAM address width.
    always_comb begin
        waddr = 7'(WBASE[layer] +
                   (32'(og) * eff_cnt(IG[layer]) + 32'(ig)) * 32'(CH_NUM * CH_NUM));
        baddr = 5'(BBASE[layer] + 32'(og) * 32'(CH_NUM));
    end

    // Descriptor fields come only from registered state, so they hold
    // steady under backpressure; outside ISSUE they read as zero.
    always_comb begin
        job_layer    = '0;
        job_src_sel  = '0;
        job_dst_sel  = '0;
        job_tile_row = '0;
        job_tile_col = '0;
        job_first_ig = 1'b0;
        job_last_ig  = 1'b0;
        job_waddr    = '0;
        job_baddr    = '0;
        if (issue_st) begin
            job_layer    = layer;
            job_src_sel  = BANK_IMG + layer;
            job_dst_sel  = layer + 3'd1;
            job_tile_row = tr;
            job_tile_col = tc;
            job_first_ig = (ig == '0);
            job_last_ig  = (ig == lim_ig - TILE_W'(1));
            job_waddr    = waddr;
            job_baddr    = baddr;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic; cnt_clr fires on every entry into ISSUE.
    always_comb begin
        state_nxt = state;
        cnt_clr   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = ISSUE;
                    cnt_clr   = 1'b1;
                end
            end
            ISSUE: begin
                if (hs && last_of_layer) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (outstanding == '0) begin
                    if (layer == LAST_LAYER) begin
                        state_nxt = FINISH;
                    end else begin
                        state_nxt = ISSUE;
                        cnt_clr   = 1'b1;
                    end
                end
            end
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Layer index: cleared on start, bumped when a non-final layer drains.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            layer <= '0;
        end else if ((state == IDLE) && start) begin
            layer <= '0;
        end else if (drained && (layer != LAST_LAYER)) begin
            layer <= layer + 3'd1;
        end
    end

    // In-flight job count; a done with nothing outstanding is flagged and ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outstanding <= '0;
            err_done    <= 1'b0;
        end else begin
            if (job_done && (outstanding == '0)) err_done <= 1'b1;
            case ({hs, done_ok})
                2'b10:   outstanding <= outstanding + OUT_W'(1);
                2'b01:   outstanding <= outstanding - OUT_W'(1);
                default: outstanding <= outstanding;
            endcase
        end
    end

`ifdef CONV_SCHED_PERF_EN
    // Saturating busy and issue-stall cycle counters, cleared on start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_busy_cyc  <= '0;
            perf_stall_cyc <= '0;
        end else if ((state == IDLE) && start) begin
            perf_busy_cyc  <= '0;
            perf_stall_cyc <= '0;
        end else begin
            if (busy && (perf_busy_cyc != '1))
                perf_busy_cyc <= perf_busy_cyc + 32'd1;
            if (issue_st && ((job_valid && !job_ready) || (outstanding == MAX_Q))
                && (perf_stall_cyc != '1))
                perf_stall_cyc <= perf_stall_cyc + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_conv_layer_sched.sv
// Scoreboard bench for conv_layer_sched: expected descriptors are queued by
// the stimulus, a negedge monitor pops and compares on every handshake.
module tb_conv_layer_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        job_ready = 1'b0;
    logic        job_done = 1'b0;
    logic        busy, valid, job_valid, err_done;
    logic [2:0]  job_layer, job_src_sel, job_dst_sel;
    logic [5:0]  job_tile_row, job_tile_col;
    logic        job_first_ig, job_last_ig;
    logic [6:0]  job_waddr;
    logic [4:0]  job_baddr;
`ifdef CONV_SCHED_PERF_EN
    logic [31:0] perf_busy_cyc, perf_stall_cyc;
`endif

    always #5 clk = ~clk;

    conv_layer_sched #(.CH_NUM(4), .TILE_W(6), .MAX_OUT(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .busy         (busy),
        .valid        (valid),
        .job_valid    (job_valid),
        .job_ready    (job_ready),
        .job_done     (job_done),
        .job_layer    (job_layer),
        .job_src_sel  (job_src_sel),
        .job_dst_sel  (job_dst_sel),
        .job_tile_row (job_tile_row),
        .job_tile_col (job_tile_col),
        .job_first_ig (job_first_ig),
        .job_last_ig  (job_last_ig),
        .job_waddr    (job_waddr),
        .job_baddr    (job_baddr),
        .err_done     (err_done)
`ifdef CONV_SCHED_PERF_EN
        ,
        .perf_busy_cyc  (perf_busy_cyc),
        .perf_stall_cyc (perf_stall_cyc)
`endif
    );

    int          total = 0;
    int          bad = 0;
    int          hs_cnt = 0;
    int          vcnt = 0;
    int          base;
    bit          auto_done = 1'b0;
    bit          found;
    logic [34:0] sb[$];
    int          pend[$];
    logic [34:0] cur;

    assign cur = {job_layer, job_src_sel, job_dst_sel, job_tile_row, job_tile_col,
                  job_first_ig, job_last_ig, job_waddr, job_baddr};

    function automatic logic [34:0] pk(int l, int s, int d, int tr, int tc,
                                       int f, int la, int wa, int ba);
        return {3'(l), 3'(s), 3'(d), 6'(tr), 6'(tc), 1'(f), 1'(la), 7'(wa), 5'(ba)};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_done();
        job_done = 1'b1;
        tick();
        job_done = 1'b0;
    endtask

    // Hand-derived descriptor list for one full pass over the package table.
    task automatic push_pass();
        // layer 0: IG=2, TC=3, WBASE 0, BBASE 0
        sb.push_back(pk(0, 0, 1, 0, 0, 1, 0,   0,  0));
        sb.push_back(pk(0, 0, 1, 0, 0, 0, 1,  16,  0));
        sb.push_back(pk(0, 0, 1, 0, 1, 1, 0,   0,  0));
        sb.push_back(pk(0, 0, 1, 0, 1, 0, 1,  16,  0));
        sb.push_back(pk(0, 0, 1, 0, 2, 1, 0,   0,  0));
        sb.push_back(pk(0, 0, 1, 0, 2, 0, 1,  16,  0));
        // layer 1: OG=2, WBASE 32, BBASE 4
        sb.push_back(pk(1, 1, 2, 0, 0, 1, 1,  32,  4));
        sb.push_back(pk(1, 1, 2, 0, 0, 1, 1,  48,  8));
        // layer 2: TR=2, TC=2
        sb.push_back(pk(2, 2, 3, 0, 0, 1, 1,  64, 12));
        sb.push_back(pk(2, 2, 3, 0, 1, 1, 1,  64, 12));
        sb.push_back(pk(2, 2, 3, 1, 0, 1, 1,  64, 12));
        sb.push_back(pk(2, 2, 3, 1, 1, 1, 1,  64, 12));
        // layers 3, 4 (OG=0 runs once)
        sb.push_back(pk(3, 3, 4, 0, 0, 1, 1,  80, 16));
        sb.push_back(pk(4, 4, 5, 0, 0, 1, 1,  96, 20));
        // layer 5: OG=2, addresses wrap (120+16 -> 8, 30+4 -> 2), dst = temp
        sb.push_back(pk(5, 5, 6, 0, 0, 1, 1, 120, 30));
        sb.push_back(pk(5, 5, 6, 0, 0, 1, 1,   8,  2));
    endtask

    // Monitor: compares each accepted descriptor against the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            if (valid) vcnt++;
            if (job_valid && job_ready) begin
                hs_cnt++;
                if (auto_done) pend.push_back(2);
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL job_unexpected got=%h want=none", cur);
                end else begin
                    logic [34:0] e;
                    e = sb.pop_front();
                    if (cur !== e) begin
                        bad++;
                        $display("FAIL job_desc got=%h want=%h", cur, e);
                    end
                end
            end
        end
    end

    // Engine model: returns job_done two cycles after each handshake.
    initial forever begin
        @(posedge clk);
        #1;
        if (auto_done) begin
            job_done = 1'b0;
            foreach (pend[i]) pend[i]--;
            if (pend.size() > 0 && pend[0] <= 0) begin
                void'(pend.pop_front());
                job_done = 1'b1;
            end
        end
    end

    initial begin
        // reset state
        repeat (3) tick();
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_valid", valid, 0);
        chk("rst_job_valid", job_valid, 0);
        chk("rst_fields", cur, 0);
        chk("rst_err", err_done, 0);
        @(posedge clk); #1; rst = 1'b0;
        tick(); tick();
        chk("idle_job_valid", job_valid, 0);

        // full pass with a well-behaved engine
        push_pass();
        job_ready = 1'b1;
        auto_done = 1'b1;
        base = hs_cnt;
        vcnt = 0;
        start = 1'b1; tick(); start = 1'b0;
        @(negedge clk);
        chk("start_busy", busy, 1);
        chk("start_job_valid", job_valid, 1);
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            @(negedge clk);
            if (valid) begin
                found = 1'b1;
                chk("finish_busy_low", busy, 0);
            end
        end
        chk("finish_seen", found, 1);
        tick();
        @(negedge clk);
        chk("valid_one_cycle", valid, 0);
        chk("busy_after", busy, 0);
        chk("valid_pulses", vcnt, 1);
        chk("pass_jobs", hs_cnt - base, 16);
        chk("sb_empty", sb.size(), 0);
        chk("pass_err", err_done, 0);

        // outstanding limit with the engine holding job_done low
        auto_done = 1'b0;
        job_done = 1'b0;
        push_pass();
        base = hs_cnt;
        start = 1'b1; tick(); start = 1'b0;
        repeat (6) tick();
        @(negedge clk);
        chk("bp_four_issued", hs_cnt - base, 4);
        chk("bp_valid_low", job_valid, 0);
        pulse_done();
        repeat (3) tick();
        @(negedge clk);
        chk("bp_one_more", hs_cnt - base, 5);
        chk("bp_valid_low2", job_valid, 0);
        job_ready = 1'b0;
        pulse_done();
        @(negedge clk);
        chk("bp_valid_reopen", job_valid, 1);
        @(posedge clk); #1;
        job_ready = 1'b1;
        job_done = 1'b1;          // handshake and done in the same cycle
        tick();
        job_done = 1'b0;
        @(negedge clk);
        chk("bp_last_l0", hs_cnt - base, 6);
        chk("bp_drain_valid", job_valid, 0);
        pulse_done();
        pulse_done();
        tick();
        @(negedge clk);
        chk("bp_still_draining", job_valid, 0);
        pulse_done();
        auto_done = 1'b1;
        tick();
        @(negedge clk);
        chk("bp_layer1_valid", job_valid, 1);
        chk("bp_layer1_idx", job_layer, 1);

        // asynchronous reset in the middle of layer 2
        found = 1'b0;
        for (int i = 0; i < 80 && !found; i++) begin
            @(negedge clk);
            if (job_valid && job_layer == 3'd2) found = 1'b1;
        end
        chk("reach_layer2", found, 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_job_valid", job_valid, 0);
        chk("mid_rst_fields", cur, 0);
        chk("mid_rst_valid", valid, 0);
        auto_done = 1'b0;
        job_done = 1'b0;
        pend.delete();
        sb.delete();
        @(posedge clk); #1; rst = 1'b0;
        tick();
        @(negedge clk);
        chk("post_rst_idle", busy, 0);
        chk("post_rst_err", err_done, 0);

        // stray job_done after reset release
        pulse_done();
        @(negedge clk);
        chk("err_set", err_done, 1);
        repeat (3) tick();
        @(negedge clk);
        chk("err_sticky", err_done, 1);

`ifdef CONV_SCHED_PERF_EN
        // five ISSUE cycles with job_ready low
        rst = 1'b1; tick(); rst = 1'b0;
        job_ready = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        repeat (5) tick();
        chk("perf_stall", perf_stall_cyc, 5);
        chk("perf_busy", perf_busy_cyc, 5);
        rst = 1'b1; tick(); rst = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
